ysyx_22050550_wbu: RTL and testbench

- Write-back/commit unit: the producer side of the register-file/CSR write interface.
- Accepts one retiring instruction per handshake from the memory stage and resolves GPR writes, CSR read-modify-writes, ECALL trap entry and MRET.
- Drives registered GPR, PC-commit and CSR write ports into the regfile, plus a one-cycle PC redirect to the fetch stage.
- CSR source values are read from the regfile's current CSR outputs.

---
 rtl/ysyx_22050550_wbu_pkg.sv | 42 ++++
 rtl/ysyx_22050550_wbu_csrcalc.sv | 104 ++++++++++
 rtl/ysyx_22050550_wbu.sv | 198 +++++++++++++++++++
 tb/tb_ysyx_22050550_wbu.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050550_wbu_pkg.sv
// Shared encodings for the write-back unit: ops, CSR map, enable bits, mstatus fields.
package ysyx_22050550_wbu_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_CSRRW = 3'd1;
    localparam logic [2:0] OP_CSRRS = 3'd2;
    localparam logic [2:0] OP_CSRRC = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int CSREN_MEPC    = 0;
    localparam int CSREN_MCAUSE  = 1;
    localparam int CSREN_MTVEC   = 2;
    localparam int CSREN_MSTATUS = 3;
    localparam int CSREN_MIE     = 4;
    localparam int CSREN_MIP     = 5;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_COMMIT     = 2'd1,
        ST_COMMIT_CSR = 2'd2,
        ST_BUBBLE     = 2'd3
    } wbu_state_e;

    // CSRRW/CSRRS/CSRRC
    function automatic logic is_csr_rw(input logic [2:0] op);
        return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
    endfunction

endpackage

// File: rtl/ysyx_22050550_wbu_csrcalc.sv
// Combinational CSR resolution: old value for rd, new CSR values, write enables and trap redirect.
module ysyx_22050550_wbu_csrcalc
    import ysyx_22050550_wbu_pkg::*;
#(
    parameter logic [63:0] ECALL_CAUSE = 64'd11,
    parameter logic [1:0]  TRAP_MPP    = 2'b11
) (
    input  logic [2:0]  op,
    input  logic [11:0] csr_addr,
    input  logic [63:0] csr_src,
    input  logic [63:0] pc,
    input  logic [63:0] cur_mepc,
    input  logic [63:0] cur_mcause,
    input  logic [63:0] cur_mtvec,
    input  logic [63:0] cur_mstatus,
    input  logic [63:0] cur_mie,
    input  logic [63:0] cur_mip,
    output logic        csr_rw,
    output logic        sys_op,
    output logic [63:0] old_val,
    output logic [7:0]  csren,
    output logic [63:0] new_mepc,
    output logic [63:0] new_mcause,
    output logic [63:0] new_mtvec,
    output logic [63:0] new_mstatus,
    output logic [63:0] new_mie,
    output logic [63:0] new_mip,
    output logic        redirect,
    output logic [63:0] redirect_pc
);

    logic [7:0]  sel;
    logic [63:0] wval;
    logic [63:0] ms;

    // Decode the addressed CSR, compute its new value, then overlay trap/return effects.
    always_comb begin
        csr_rw      = is_csr_rw(op);
        sys_op      = (op == OP_ECALL) || (op == OP_MRET);
        sel         = 8'b0;
        old_val     = 64'd0;
        wval        = 64'd0;
        ms          = cur_mstatus;
        csren       = 8'b0;
        new_mepc    = cur_mepc;
        new_mcause  = cur_mcause;
        new_mtvec   = cur_mtvec;
        new_mstatus = cur_mstatus;
        new_mie     = cur_mie;
        new_mip     = cur_mip;
        redirect    = 1'b0;
        redirect_pc = 64'd0;

        // unmapped addresses read as zero and select nothing
        case (csr_addr)
            CSR_MEPC:    begin old_val = cur_mepc;    sel[CSREN_MEPC]    = 1'b1; end
            CSR_MCAUSE:  begin old_val = cur_mcause;  sel[CSREN_MCAUSE]  = 1'b1; end
            CSR_MTVEC:   begin old_val = cur_mtvec;   sel[CSREN_MTVEC]   = 1'b1; end
            CSR_MSTATUS: begin old_val = cur_mstatus; sel[CSREN_MSTATUS] = 1'b1; end
            CSR_MIE:     begin old_val = cur_mie;     sel[CSREN_MIE]     = 1'b1; end
            CSR_MIP:     begin old_val = cur_mip;     sel[CSREN_MIP]     = 1'b1; end
            default:     ;
        endcase

        case (op)
            OP_CSRRW: wval = csr_src;
            OP_CSRRS: wval = old_val | csr_src;
            OP_CSRRC: wval = old_val & ~csr_src;
            default:  wval = 64'd0;
        endcase

        if (csr_rw) begin
            // set/clear with a zero source still writes (value unchanged)
            csren = sel;
            if (sel[CSREN_MEPC])    new_mepc    = wval;
            if (sel[CSREN_MCAUSE])  new_mcause  = wval;
            if (sel[CSREN_MTVEC])   new_mtvec   = wval;
            if (sel[CSREN_MSTATUS]) new_mstatus = wval;
            if (sel[CSREN_MIE])     new_mie     = wval;
            if (sel[CSREN_MIP])     new_mip     = wval;
        end else if (op == OP_ECALL) begin
            ms[MSTATUS_MPIE]                  = cur_mstatus[MSTATUS_MIE];
            ms[MSTATUS_MIE]                   = 1'b0;
            ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = TRAP_MPP;
            new_mepc    = pc;
            new_mcause  = ECALL_CAUSE;
            new_mstatus = ms;
            csren[CSREN_MEPC]    = 1'b1;
            csren[CSREN_MCAUSE]  = 1'b1;
            csren[CSREN_MSTATUS] = 1'b1;
            redirect    = 1'b1;
            redirect_pc = cur_mtvec & ~64'h3;
        end else if (op == OP_MRET) begin
            ms[MSTATUS_MIE]                   = cur_mstatus[MSTATUS_MPIE];
            ms[MSTATUS_MPIE]                  = 1'b1;
            ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
            new_mstatus = ms;
            csren[CSREN_MSTATUS] = 1'b1;
            redirect    = 1'b1;
            redirect_pc = cur_mepc;
        end
    end

endmodule

// File: rtl/ysyx_22050550_wbu.sv
// Write-back/commit unit: registers GPR, PC-commit and CSR writes toward the regfile.
//
// state         | meaning
// --------------+---------------------------------------------------------
// ST_IDLE       | nothing committing, ready to accept
// ST_COMMIT     | ordinary commit outputs valid, still ready (back-to-back)
// ST_COMMIT_CSR | CSR/ECALL/MRET commit outputs valid, not ready
// ST_BUBBLE     | regfile CSR outputs settling after the write, not ready
module ysyx_22050550_wbu
    import ysyx_22050550_wbu_pkg::*;
#(
    parameter logic [63:0] ECALL_CAUSE = 64'd11,
    parameter logic [1:0]  TRAP_MPP    = 2'b11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic [2:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_wen,
    input  logic [63:0] in_rd_data,
    input  logic [11:0] in_csr_addr,
    input  logic [63:0] in_csr_src,
    input  logic [63:0] cur_mepc,
    input  logic [63:0] cur_mcause,
    input  logic [63:0] cur_mtvec,
    input  logic [63:0] cur_mstatus,
    input  logic [63:0] cur_mie,
    input  logic [63:0] cur_mip,
    output logic [4:0]  io_waddr,
    output logic [63:0] io_wdata,
    output logic        io_wen,
    output logic        io_valid,
    output logic [63:0] pc,
    output logic [7:0]  wbcsren,
    output logic [63:0] wbmepc,
    output logic [63:0] wbmcause,
    output logic [63:0] wbmtvec,
    output logic [63:0] wbmstatus,
    output logic [63:0] wbmie,
    output logic [63:0] wbmip,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc
);

    wbu_state_e  state_q, state_d;
    logic        accept;

    logic        calc_csr_rw, calc_sys_op, calc_redirect;
    logic [63:0] calc_old, calc_redirect_pc;
    logic [7:0]  calc_csren;
    logic [63:0] calc_mepc, calc_mcause, calc_mtvec, calc_mstatus, calc_mie, calc_mip;

    logic [4:0]  io_waddr_q, io_waddr_d;
    logic [63:0] io_wdata_q, io_wdata_d;
    logic        io_wen_q, io_wen_d;
    logic        io_valid_q, io_valid_d;
    logic [63:0] pc_q, pc_d;
    logic [7:0]  wbcsren_q, wbcsren_d;
    logic [63:0] wbmepc_q, wbmepc_d, wbmcause_q, wbmcause_d, wbmtvec_q, wbmtvec_d;
    logic [63:0] wbmstatus_q, wbmstatus_d, wbmie_q, wbmie_d, wbmip_q, wbmip_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [63:0] redirect_pc_q, redirect_pc_d;

    ysyx_22050550_wbu_csrcalc #(
        .ECALL_CAUSE (ECALL_CAUSE),
        .TRAP_MPP    (TRAP_MPP)
    ) u_csrcalc (
        .op          (in_op),
        .csr_addr    (in_csr_addr),
        .csr_src     (in_csr_src),
        .pc          (in_pc),
        .cur_mepc    (cur_mepc),
        .cur_mcause  (cur_mcause),
        .cur_mtvec   (cur_mtvec),
        .cur_mstatus (cur_mstatus),
        .cur_mie     (cur_mie),
        .cur_mip     (cur_mip),
        .csr_rw      (calc_csr_rw),
        .sys_op      (calc_sys_op),
        .old_val     (calc_old),
        .csren       (calc_csren),
        .new_mepc    (calc_mepc),
        .new_mcause  (calc_mcause),
        .new_mtvec   (calc_mtvec),
        .new_mstatus (calc_mstatus),
        .new_mie     (calc_mie),
        .new_mip     (calc_mip),
        .redirect    (calc_redirect),
        .redirect_pc (calc_redirect_pc)
    );

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_COMMIT);
    assign accept   = in_valid && in_ready;

    // Next state and next output values; pulses default low, data holds.
    always_comb begin
        state_d          = state_q;
        io_valid_d       = 1'b0;
        io_wen_d         = 1'b0;
        wbcsren_d        = 8'b0;
        redirect_valid_d = 1'b0;
        io_waddr_d       = io_waddr_q;
        io_wdata_d       = io_wdata_q;
        pc_d             = pc_q;
        wbmepc_d         = wbmepc_q;
        wbmcause_d       = wbmcause_q;
        wbmtvec_d        = wbmtvec_q;
        wbmstatus_d      = wbmstatus_q;
        wbmie_d          = wbmie_q;
        wbmip_d          = wbmip_q;
        redirect_pc_d    = redirect_pc_q;

        case (state_q)
            ST_IDLE, ST_COMMIT: begin
                if (accept)
                    state_d = (calc_csr_rw || calc_sys_op) ? ST_COMMIT_CSR : ST_COMMIT;
                else
                    state_d = ST_IDLE;
            end
            ST_COMMIT_CSR: state_d = ST_BUBBLE;
            ST_BUBBLE:     state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase

        if (accept) begin
            io_valid_d       = 1'b1;
            pc_d             = in_pc;
            io_waddr_d       = in_rd;
            io_wdata_d       = calc_csr_rw ? calc_old : in_rd_data;
            io_wen_d         = !calc_sys_op && in_rd_wen && (in_rd != 5'd0);
            wbcsren_d        = {2'b00, calc_csren[5:0]};
            wbmepc_d         = calc_mepc;
            wbmcause_d       = calc_mcause;
            wbmtvec_d        = calc_mtvec;
            wbmstatus_d      = calc_mstatus;
            wbmie_d          = calc_mie;
            wbmip_d          = calc_mip;
            redirect_valid_d = calc_redirect;
            redirect_pc_d    = calc_redirect_pc;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            io_waddr_q       <= 5'd0;
            io_wdata_q       <= 64'd0;
            io_wen_q         <= 1'b0;
            io_valid_q       <= 1'b0;
            pc_q             <= 64'd0;
            wbcsren_q        <= 8'b0;
            wbmepc_q         <= 64'd0;
            wbmcause_q       <= 64'd0;
            wbmtvec_q        <= 64'd0;
            wbmstatus_q      <= 64'd0;
            wbmie_q          <= 64'd0;
            wbmip_q          <= 64'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 64'd0;
        end else begin
            state_q          <= state_d;
            io_waddr_q       <= io_waddr_d;
            io_wdata_q       <= io_wdata_d;
            io_wen_q         <= io_wen_d;
            io_valid_q       <= io_valid_d;
            pc_q             <= pc_d;
            wbcsren_q        <= wbcsren_d;
            wbmepc_q         <= wbmepc_d;
            wbmcause_q       <= wbmcause_d;
            wbmtvec_q        <= wbmtvec_d;
            wbmstatus_q      <= wbmstatus_d;
            wbmie_q          <= wbmie_d;
            wbmip_q          <= wbmip_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign io_waddr       = io_waddr_q;
    assign io_wdata       = io_wdata_q;
    assign io_wen         = io_wen_q;
    assign io_valid       = io_valid_q;
    assign pc             = pc_q;
    assign wbcsren        = wbcsren_q;
    assign wbmepc         = wbmepc_q;
    assign wbmcause       = wbmcause_q;
    assign wbmtvec        = wbmtvec_q;
    assign wbmstatus      = wbmstatus_q;
    assign wbmie          = wbmie_q;
    assign wbmip          = wbmip_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ysyx_22050550_wbu.sv
// Randomized bench for the write-back unit with a transaction-level reference model.
module tb_ysyx_22050550_wbu;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [2:0]  in_op;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [63:0] in_rd_data;
    logic [11:0] in_csr_addr;
    logic [63:0] in_csr_src;
    logic [63:0] cur [6];
    logic [4:0]  io_waddr;
    logic [63:0] io_wdata;
    logic        io_wen;
    logic        io_valid;
    logic [63:0] pc;
    logic [7:0]  wbcsren;
    logic [63:0] wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] dut_wb [6];

    always #5 clock = ~clock;

    ysyx_22050550_wbu dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_op          (in_op),
        .in_rd          (in_rd),
        .in_rd_wen      (in_rd_wen),
        .in_rd_data     (in_rd_data),
        .in_csr_addr    (in_csr_addr),
        .in_csr_src     (in_csr_src),
        .cur_mepc       (cur[0]),
        .cur_mcause     (cur[1]),
        .cur_mtvec      (cur[2]),
        .cur_mstatus    (cur[3]),
        .cur_mie        (cur[4]),
        .cur_mip        (cur[5]),
        .io_waddr       (io_waddr),
        .io_wdata       (io_wdata),
        .io_wen         (io_wen),
        .io_valid       (io_valid),
        .pc             (pc),
        .wbcsren        (wbcsren),
        .wbmepc         (wbmepc),
        .wbmcause       (wbmcause),
        .wbmtvec        (wbmtvec),
        .wbmstatus      (wbmstatus),
        .wbmie          (wbmie),
        .wbmip          (wbmip),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    assign dut_wb[0] = wbmepc;
    assign dut_wb[1] = wbmcause;
    assign dut_wb[2] = wbmtvec;
    assign dut_wb[3] = wbmstatus;
    assign dut_wb[4] = wbmie;
    assign dut_wb[5] = wbmip;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: cycles left before ready, plus the expected registered outputs
    int          m_busy;
    logic        e_valid, e_wen, e_rv;
    logic [4:0]  e_waddr;
    logic [63:0] e_wdata, e_pc, e_rpc;
    logic [7:0]  e_csren;
    logic [63:0] e_wb [6];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int csr_idx(input logic [11:0] a);
        case (a)
            12'h341: return 0;
            12'h342: return 1;
            12'h305: return 2;
            12'h300: return 3;
            12'h304: return 4;
            12'h344: return 5;
            default: return -1;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] p,
                         input logic [4:0] rd, input logic wen, input logic [63:0] data,
                         input logic [11:0] addr, input logic [63:0] src);
        in_valid    = v;
        in_op       = op;
        in_pc       = p;
        in_rd       = rd;
        in_rd_wen   = wen;
        in_rd_data  = data;
        in_csr_addr = addr;
        in_csr_src  = src;
    endtask

    // Called at a negedge with inputs driven: predict, clock once, compare.
    task automatic step();
        logic        acc;
        int          idx;
        logic [63:0] old, nv, ms;
        chk("in_ready", {63'd0, in_ready}, {63'd0, m_busy == 0});
        acc     = in_valid && (m_busy == 0);
        e_valid = acc;
        e_wen   = 1'b0;
        e_csren = 8'h00;
        e_rv    = 1'b0;
        if (!acc) begin
            if (m_busy > 0) m_busy--;
        end else begin
            e_pc = in_pc;
            case (in_op)
                3'd1, 3'd2, 3'd3: begin
                    idx = csr_idx(in_csr_addr);
                    old = (idx >= 0) ? cur[idx] : 64'd0;
                    if (in_op == 3'd1)      nv = in_csr_src;
                    else if (in_op == 3'd2) nv = old | in_csr_src;
                    else                    nv = old & ~in_csr_src;
                    if (idx >= 0) begin
                        e_csren[idx] = 1'b1;
                        e_wb[idx]    = nv;
                    end
                    e_wen   = in_rd_wen && (in_rd != 0);
                    e_waddr = in_rd;
                    e_wdata = old;
                    m_busy  = 2;
                end
                3'd4: begin
                    ms = cur[3];
                    ms[7] = ms[3];
                    ms[3] = 1'b0;
                    ms[12:11] = 2'b11;
                    e_wb[0] = in_pc;
                    e_wb[1] = 64'd11;
                    e_wb[3] = ms;
                    e_csren = 8'h0B;
                    e_rv    = 1'b1;
                    e_rpc   = cur[2] & ~64'h3;
                    m_busy  = 2;
                end
                3'd5: begin
                    ms = cur[3];
                    ms[3] = ms[7];
                    ms[7] = 1'b1;
                    ms[12:11] = 2'b00;
                    e_wb[3] = ms;
                    e_csren = 8'h08;
                    e_rv    = 1'b1;
                    e_rpc   = cur[0];
                    m_busy  = 2;
                end
                default: begin
                    e_wen   = in_rd_wen && (in_rd != 0);
                    e_waddr = in_rd;
                    e_wdata = in_rd_data;
                end
            endcase
        end
        @(posedge clock);
        #1;
        chk("io_valid", {63'd0, io_valid}, {63'd0, e_valid});
        chk("io_wen", {63'd0, io_wen}, {63'd0, e_wen});
        chk("wbcsren", {56'd0, wbcsren}, {56'd0, e_csren});
        chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, e_rv});
        chk("pc", pc, e_pc);
        if (e_wen) begin
            chk("io_waddr", {59'd0, io_waddr}, {59'd0, e_waddr});
            chk("io_wdata", io_wdata, e_wdata);
        end
        for (int i = 0; i < 6; i++)
            if (e_csren[i]) chk($sformatf("wb_csr%0d", i), dut_wb[i], e_wb[i]);
        if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_io_valid"}, {63'd0, io_valid}, 64'd0);
        chk({tag, "_io_wen"}, {63'd0, io_wen}, 64'd0);
        chk({tag, "_io_wdata"}, io_wdata, 64'd0);
        chk({tag, "_io_waddr"}, {59'd0, io_waddr}, 64'd0);
        chk({tag, "_pc"}, pc, 64'd0);
        chk({tag, "_wbcsren"}, {56'd0, wbcsren}, 64'd0);
        chk({tag, "_redirect_valid"}, {63'd0, redirect_valid}, 64'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 64'd0);
        for (int i = 0; i < 6; i++) chk($sformatf("%s_wb%0d", tag, i), dut_wb[i], 64'd0);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic model_reset();
        m_busy  = 0;
        e_pc    = 64'd0;
        e_valid = 1'b0;
        e_wen   = 1'b0;
        e_rv    = 1'b0;
        e_csren = 8'h00;
    endtask

    initial begin
        logic [11:0] addr;
        logic [2:0]  op;
        reset = 1'b1;
        drive(1'b0, 3'd0, 64'd0, 5'd0, 1'b0, 64'd0, 12'd0, 64'd0);
        for (int i = 0; i < 6; i++) cur[i] = 64'd0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        // two back-to-back ordinary writes to x5
        drive(1'b1, 3'd0, 64'h8000_0000, 5'd5, 1'b1, 64'hDEAD, 12'd0, 64'd0);
        step();
        drive(1'b1, 3'd0, 64'h8000_0004, 5'd5, 1'b1, 64'hDEAD, 12'd0, 64'd0);
        step();
        chk("b2b_wdata", io_wdata, 64'hDEAD);

        // write to x0 is suppressed but still commits
        drive(1'b1, 3'd0, 64'h8000_0008, 5'd0, 1'b1, 64'h1234, 12'd0, 64'd0);
        step();
        chk("x0_io_valid", {63'd0, io_valid}, 64'd1);

        // CSRRS mstatus, then valid held through the two not-ready cycles
        cur[3] = 64'hA_0000_1800;
        drive(1'b1, 3'd2, 64'h8000_000C, 5'd3, 1'b1, 64'd0, 12'h300, 64'h8);
        step();
        chk("csrrs_wdata", io_wdata, 64'hA_0000_1800);
        chk("csrrs_wbmstatus", wbmstatus, 64'hA_0000_1808);
        chk("csrrs_wbcsren", {56'd0, wbcsren}, 64'h08);
        step();
        step();

        // ECALL with MIE set
        drive(1'b1, 3'd4, 64'h8000_0010, 5'd7, 1'b1, 64'h55, 12'd0, 64'd0);
        cur[2] = 64'h8000_0101;
        cur[3] = 64'h8;
        step();
        chk("ecall_wbmepc", wbmepc, 64'h8000_0010);
        chk("ecall_wbmcause", wbmcause, 64'd11);
        chk("ecall_wbmstatus", wbmstatus, 64'h1880);
        chk("ecall_redirect_pc", redirect_pc, 64'h8000_0100);
        in_valid = 1'b0;
        step();
        step();

        // MRET with MPIE set, MIE clear
        cur[0] = 64'h8000_0014;
        cur[3] = 64'h80;
        drive(1'b1, 3'd5, 64'h8000_0020, 5'd1, 1'b1, 64'd0, 12'd0, 64'd0);
        step();
        chk("mret_wbmstatus", wbmstatus, 64'h88);
        chk("mret_redirect_pc", redirect_pc, 64'h8000_0014);
        in_valid = 1'b0;
        step();
        step();

        // async reset while a CSR commit is on the outputs
        cur[0] = 64'h1111;
        drive(1'b1, 3'd1, 64'h8000_0030, 5'd9, 1'b1, 64'd0, 12'h341, 64'h4444);
        step();
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        drive(1'b1, 3'd0, 64'h8000_0040, 5'd2, 1'b1, 64'h77, 12'd0, 64'd0);
        step();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 6; i++) cur[i] = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: addr = 12'h341;
                1: addr = 12'h342;
                2: addr = 12'h305;
                3: addr = 12'h300;
                4: addr = 12'h304;
                5: addr = 12'h344;
                default: addr = 12'($urandom_range(0, 4095));
            endcase
            op = 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 3) != 0), op, {$urandom, $urandom},
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, addr,
                  ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom});
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
